// File: rtl/mod3_controle_rega_pkg.sv
// Shared state and mode codes for the irrigation sequencer and its status display.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mod3_controle_rega_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_COOL  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic MODE_VS = 1'b1;  // sprinkler
    localparam logic MODE_BS = 1'b0;  // drip

endpackage

// File: rtl/mod3_controle_rega_timer.sv
// Tick counter for the sequencer.
// Latency: count updates one clock after tick.
// Backpressure: none. Clear beats tick. Count saturates at sat_val.
//
// Ports: clear   - zero the count (state change)
//        tick    - timebase pulse, increments count
//        sat_val - ceiling the count never exceeds
//        term_val - terminal value for done
//        count   - current tick count
//        done    - count == term_val (combinational)
module rega_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] sat_val,
    input  logic [CNT_W-1:0] term_val,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count < sat_val)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == term_val);

endmodule

// File: rtl/mod3_controle_rega.sv
// Irrigation sequencer: prime pump, timed valve run, cool-down, latched conflict fault.
// Latency: all outputs are flops, updated one clock after the inputs that cause them.
// Backpressure: none. Level requests are sampled every clock; timing counts tick pulses.
//
// Ports: clk, rst_n (async active-low), tick (timebase enable),
//        vs_req / bs_req (sprinkler / drip requests), tank_low (inhibit pump),
//        pump, valve_vs, valve_bs (actuators), busy, fault, state (status).
module mod3_controle_rega
    import mod3_controle_rega_pkg::*;
#(
    parameter int PRIME_TICKS = 3,
    parameter int MIN_TICKS   = 10,
    parameter int MAX_TICKS   = 60,
    parameter int COOL_TICKS  = 5,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       vs_req,
    input  logic       bs_req,
    input  logic       tank_low,
    output logic       pump,
    output logic       valve_vs,
    output logic       valve_bs,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PRIME_TICKS - 1);
    localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_TICKS - 1);
    localparam logic [CNT_W-1:0] MIN_VAL    = CNT_W'(MIN_TICKS);
    localparam logic [CNT_W-1:0] MAX_VAL    = CNT_W'(MAX_TICKS);

    state_t           state_q, state_nxt;
    logic             mode_q, mode_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term_val;
    logic             cnt_done;
    logic             cnt_clear;
    logic             both_req;
    logic             mode_req;
    logic             tick_done;

    assign both_req  = vs_req & bs_req;
    assign mode_req  = (mode_q == MODE_VS) ? vs_req : bs_req;
    assign tick_done = tick & cnt_done;
    // The tick on a transition edge belongs to the old state; the new one starts at 0.
    assign cnt_clear = (state_nxt != state_q);

    always_comb begin
        term_val = MAX_LAST;
        case (state_q)
            ST_PRIME: term_val = PRIME_LAST;
            ST_COOL:  term_val = COOL_LAST;
            default:  term_val = MAX_LAST;
        endcase
    end

    rega_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .tick     (tick),
        .sat_val  (MAX_VAL),
        .term_val (term_val),
        .count    (cnt),
        .done     (cnt_done)
    );

    always_comb begin
        state_nxt = state_q;
        mode_nxt  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (both_req) begin
                    state_nxt = ST_FAULT;
                end else if (tank_low) begin
                    state_nxt = ST_IDLE;
                end else if (vs_req) begin
                    state_nxt = ST_PRIME;
                    mode_nxt  = MODE_VS;
                end else if (bs_req) begin
                    state_nxt = ST_PRIME;
                    mode_nxt  = MODE_BS;
                end
            end
            ST_PRIME: begin
                // A dropped request still completes priming; RUN then exits at the minimum.
                if (tank_low)       state_nxt = ST_COOL;
                else if (both_req)  state_nxt = ST_FAULT;
                else if (tick_done) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // The other mode's request alone is ignored until this cycle ends.
                if (tank_low)                           state_nxt = ST_COOL;
                else if (both_req)                      state_nxt = ST_FAULT;
                else if (tick_done)                     state_nxt = ST_COOL;
                else if ((cnt >= MIN_VAL) && !mode_req) state_nxt = ST_COOL;
            end
            ST_COOL: begin
                if (tick_done) state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                if (!vs_req && !bs_req) state_nxt = ST_COOL;
            end
            default: state_nxt = ST_FAULT;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_BS;
            pump     <= 1'b0;
            valve_vs <= 1'b0;
            valve_bs <= 1'b0;
            busy     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            mode_q   <= mode_nxt;
            pump     <= (state_nxt == ST_PRIME) || (state_nxt == ST_RUN);
            valve_vs <= (state_nxt == ST_RUN) && (mode_nxt == MODE_VS);
            valve_bs <= (state_nxt == ST_RUN) && (mode_nxt == MODE_BS);
            busy     <= (state_nxt != ST_IDLE);
            fault    <= (state_nxt == ST_FAULT);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mod3_controle_rega.sv
module tb_mod3_controle_rega;

    localparam int P_PRIME = 2;
    localparam int P_MIN   = 3;
    localparam int P_MAX   = 6;
    localparam int P_COOL  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       vs_req = 1'b0;
    logic       bs_req = 1'b0;
    logic       tank_low = 1'b0;
    logic       pump, valve_vs, valve_bs, busy, fault;
    logic [2:0] state;

    mod3_controle_rega #(
        .PRIME_TICKS (P_PRIME),
        .MIN_TICKS   (P_MIN),
        .MAX_TICKS   (P_MAX),
        .COOL_TICKS  (P_COOL),
        .CNT_W       (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .vs_req   (vs_req),
        .bs_req   (bs_req),
        .tank_low (tank_low),
        .pump     (pump),
        .valve_vs (valve_vs),
        .valve_bs (valve_bs),
        .busy     (busy),
        .fault    (fault),
        .state    (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // Reference model: phase 0..4 = idle/prime/run/cool/fault, ticks elapsed in phase.
    int ph = 0;
    int el = 0;
    bit md = 1'b0;
    int tdiv = 0;

    function automatic logic [7:0] model_outputs();
        logic [2:0] s;
        s = 3'(ph);
        return {s, (ph == 1) || (ph == 2), (ph == 2) && md, (ph == 2) && !md, ph != 0, ph == 4};
    endfunction

    task automatic model_step(input bit v, input bit b, input bit t, input bit k);
        int nx;
        nx = ph;
        case (ph)
            0: begin
                if (v && b) nx = 4;
                else if (!t && (v || b)) begin
                    nx = 1;
                    md = v;
                end
            end
            1: begin
                if (t) nx = 3;
                else if (v && b) nx = 4;
                else if (k && (el + 1 == P_PRIME)) nx = 2;
            end
            2: begin
                if (t) nx = 3;
                else if (v && b) nx = 4;
                else if (k && (el + 1 == P_MAX)) nx = 3;
                else if ((el >= P_MIN) && !(md ? v : b)) nx = 3;
            end
            3: if (k && (el + 1 == P_COOL)) nx = 0;
            default: if (!v && !b) nx = 3;
        endcase
        if (nx != ph) el = 0;
        else if (k && (el < P_MAX)) el = el + 1;
        ph = nx;
    endtask

    // One clock of stimulus; the expected response is queued for the monitor.
    task automatic cyc(input bit v, input bit b, input bit t);
        bit k;
        k = (tdiv == 3);
        vs_req = v;
        bs_req = b;
        tank_low = t;
        tick = k;
        @(posedge clk);
        model_step(v, b, t, k);
        exp_q.push_back(model_outputs());
        #1;
        tdiv = (tdiv + 1) % 4;
    endtask

    task automatic run(input bit v, input bit b, input bit t, input int n);
        for (int i = 0; i < n; i++) cyc(v, b, t);
    endtask

    task automatic model_reset();
        ph = 0;
        el = 0;
        md = 1'b0;
    endtask

    logic [7:0] mon_exp, mon_got;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {state, pump, valve_vs, valve_bs, busy, fault};
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL outputs t=%0t got {state,pump,vvs,vbs,busy,fault}=%b expected=%b",
                         $time, mon_got, mon_exp);
            end
            checks++;
            if ((valve_vs & valve_bs) || ((valve_vs | valve_bs) & ~pump)) begin
                errors++;
                $display("FAIL valve_invariant t=%0t pump=%b vvs=%b vbs=%b required no overlap and pump on",
                         $time, pump, valve_vs, valve_bs);
            end
        end
    end

    initial begin
        bit v, b, t;
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({state, pump, valve_vs, valve_bs, busy, fault} !== 8'd0) begin
            errors++;
            $display("FAIL reset_state got=%b required=00000000",
                     {state, pump, valve_vs, valve_bs, busy, fault});
        end
        rst_n = 1'b1;
        model_reset();

        // Normal sprinkler cycle, then idle
        run(1, 0, 0, 4 * (P_PRIME + P_MIN));
        run(0, 0, 0, 40);
        // Max cap with drip held, rolls into a second cycle after cool-down
        run(0, 1, 0, 4 * 14);
        run(0, 0, 0, 40);
        // Tank low during RUN
        run(1, 0, 0, 4 * P_PRIME + 6);
        run(1, 0, 1, 3);
        run(0, 0, 0, 20);
        // Tank low in IDLE with a request
        run(1, 0, 1, 12);
        run(0, 0, 0, 4);
        // Conflict in IDLE, then release
        run(1, 1, 0, 6);
        run(0, 0, 0, 24);
        // Mode switch mid-run
        run(1, 0, 0, 4 * P_PRIME + 6);
        run(0, 1, 0, 40);
        run(0, 0, 0, 40);

        // Reset asserted mid-RUN: outputs drop without a clock edge
        run(1, 0, 0, 14);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pump, valve_vs, valve_bs, busy, fault} !== 5'd0) begin
            errors++;
            $display("FAIL async_reset got {pump,vvs,vbs,busy,fault}=%b required=00000",
                     {pump, valve_vs, valve_bs, busy, fault});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL reset_release_state got=%0d required=0", state);
        end
        run(0, 0, 0, 8);

        // Randomised requests held in short bursts
        for (int blk = 0; blk < 250; blk++) begin
            v = ($urandom % 3) != 0;
            b = ($urandom % 4) == 0;
            t = ($urandom % 10) == 0;
            run(v, b, t, 8);
        end
        run(0, 0, 0, 60);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
